arb_resp_router: RTL and testbench

ARB_RESP_ROUTER -- requirements
Module: arb_resp_router

---
 rtl/arb_resp_router.sv | 99 +++++++++
 tb/tb_arb_resp_router.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/arb_resp_router.sv
// In-order response router: remembers which upstream port was granted each
// transaction and steers the shared response stream back to that port.

module arb_resp_slice #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sel,
  input  logic                  s_valid,
  input  logic                  s_last,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  valid,
  output logic                  last,
  output logic [DATA_WIDTH-1:0] data
);
  assign valid = sel && s_valid;
  assign last  = valid && s_last;
  assign data  = s_data;
endmodule

module arb_resp_router #(
  parameter int PORTS      = 4,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  input  logic [PW-1:0]               issue_port,
  output logic                        issue_ready,
  input  logic [DATA_WIDTH-1:0]       s_resp_data,
  input  logic                        s_resp_valid,
  input  logic                        s_resp_last,
  output logic                        s_resp_ready,
  output logic [PORTS*DATA_WIDTH-1:0] m_resp_data,
  output logic [PORTS-1:0]            m_resp_valid,
  output logic [PORTS-1:0]            m_resp_last,
  input  logic [PORTS-1:0]            m_resp_ready,
  output logic [CW-1:0]               outstanding,
  output logic                        drop_active
);
  localparam int AW = $clog2(DEPTH);

  logic [PW-1:0] fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [PW-1:0] head;
  logic          nonempty, head_ok, route_ok, push, pop;

  assign nonempty    = (count != '0);
  assign issue_ready = (count != CW'(DEPTH));
  assign outstanding = count;
  assign head        = fifo_q[rd_ptr];
  assign head_ok     = (int'(head) < PORTS);
  assign route_ok    = nonempty && head_ok;
  assign drop_active = nonempty && !head_ok;

  // Out-of-range heads are drained unconditionally so a bad grant cannot wedge the stream.
  assign s_resp_ready = nonempty && (!head_ok || m_resp_ready[head]);

  assign push = issue_valid && issue_ready;
  assign pop  = s_resp_valid && s_resp_ready && s_resp_last;

  genvar i;
  generate
    for (i = 0; i < PORTS; i++) begin : g_port
      arb_resp_slice #(.DATA_WIDTH(DATA_WIDTH)) u_slice (
        .sel     (route_ok && (head == PW'(i))),
        .s_valid (s_resp_valid),
        .s_last  (s_resp_last),
        .s_data  (s_resp_data),
        .valid   (m_resp_valid[i]),
        .last    (m_resp_last[i]),
        .data    (m_resp_data[i*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push && !rst) fifo_q[wr_ptr] <= issue_port;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_arb_resp_router.sv
// Directed bench: PORTS=4 instance for ordering/backpressure/wrap, PORTS=3 instance for drop.

module tb_arb_resp_router;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         iv4, ir4, sv4, sl4, sr4, da4;
  logic [1:0]   ip4;
  logic [31:0]  sd4;
  logic [127:0] md4;
  logic [3:0]   mv4, ml4, mr4, out4;

  logic         iv3, ir3, sv3, sl3, sr3, da3;
  logic [1:0]   ip3;
  logic [31:0]  sd3;
  logic [95:0]  md3;
  logic [2:0]   mv3, ml3, mr3;
  logic [3:0]   out3;

  int n_checks = 0;
  int n_fail   = 0;

  arb_resp_router #(.PORTS(4), .DEPTH(8), .DATA_WIDTH(32)) u_dut4 (
    .clk(clk), .rst(rst), .issue_valid(iv4), .issue_port(ip4), .issue_ready(ir4),
    .s_resp_data(sd4), .s_resp_valid(sv4), .s_resp_last(sl4), .s_resp_ready(sr4),
    .m_resp_data(md4), .m_resp_valid(mv4), .m_resp_last(ml4), .m_resp_ready(mr4),
    .outstanding(out4), .drop_active(da4)
  );

  arb_resp_router #(.PORTS(3), .DEPTH(8), .DATA_WIDTH(32)) u_dut3 (
    .clk(clk), .rst(rst), .issue_valid(iv3), .issue_port(ip3), .issue_ready(ir3),
    .s_resp_data(sd3), .s_resp_valid(sv3), .s_resp_last(sl3), .s_resp_ready(sr3),
    .m_resp_data(md3), .m_resp_valid(mv3), .m_resp_last(ml3), .m_resp_ready(mr3),
    .outstanding(out3), .drop_active(da3)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    iv4 = 0; ip4 = 0; sv4 = 0; sl4 = 0; sd4 = 0; mr4 = '1;
    iv3 = 0; ip3 = 0; sv3 = 0; sl3 = 0; sd3 = 0; mr3 = '1;
  endtask

  task automatic test_reset();
    rst = 1; idle(); tick(); tick(); rst = 0;
    sv4 = 1; sv3 = 1; #1;
    n_checks++; if (out4 !== 4'd0) begin n_fail++; $display("FAIL reset_out4 got %0d exp 0", out4); end
    n_checks++; if (ir4 !== 1'b1) begin n_fail++; $display("FAIL reset_ready4 got %b exp 1", ir4); end
    n_checks++; if (sr4 !== 1'b0) begin n_fail++; $display("FAIL reset_sready4 got %b exp 0", sr4); end
    n_checks++; if (mv4 !== 4'b0) begin n_fail++; $display("FAIL reset_mvalid4 got %b exp 0000", mv4); end
    n_checks++; if (da4 !== 1'b0) begin n_fail++; $display("FAIL reset_drop4 got %b exp 0", da4); end
    n_checks++; if (out3 !== 4'd0 || sr3 !== 1'b0 || mv3 !== 3'b0 || ir3 !== 1'b1)
      begin n_fail++; $display("FAIL reset_dut3 got out=%0d sr=%b mv=%b ir=%b", out3, sr3, mv3, ir3); end
    idle();
  endtask

  task automatic test_order();
    int seq [3] = '{2, 0, 3};
    logic [3:0] e;
    iv4 = 1;
    for (int k = 0; k < 3; k++) begin ip4 = 2'(seq[k]); tick(); end
    iv4 = 0;
    n_checks++; if (out4 !== 4'd3) begin n_fail++; $display("FAIL order_fill got %0d exp 3", out4); end
    for (int k = 0; k < 3; k++) begin
      e = 4'b0001 << seq[k];
      sv4 = 1; sl4 = 0; sd4 = 32'hA000 + 32'(k * 2); #1;
      n_checks++; if (mv4 !== e || ml4 !== 4'b0) begin n_fail++; $display("FAIL order_beat0_%0d got mv=%b ml=%b exp mv=%b ml=0000", k, mv4, ml4, e); end
      n_checks++; if (md4[seq[k]*32 +: 32] !== 32'hA000 + 32'(k * 2) || sr4 !== 1'b1)
        begin n_fail++; $display("FAIL order_data_%0d got %h sr=%b", k, md4[seq[k]*32 +: 32], sr4); end
      tick();
      n_checks++; if (out4 !== 4'(3 - k)) begin n_fail++; $display("FAIL order_nonlast_%0d got %0d exp %0d", k, out4, 3 - k); end
      sl4 = 1; sd4 = sd4 + 1; #1;
      n_checks++; if (ml4 !== e) begin n_fail++; $display("FAIL order_last_%0d got %b exp %b", k, ml4, e); end
      tick();
      n_checks++; if (out4 !== 4'(2 - k)) begin n_fail++; $display("FAIL order_pop_%0d got %0d exp %0d", k, out4, 2 - k); end
    end
    idle();
  endtask

  task automatic test_full();
    int drain [7] = '{2, 3, 0, 1, 2, 3, 1};
    iv4 = 1;
    for (int i = 0; i < 8; i++) begin ip4 = 2'(i); tick(); end
    n_checks++; if (out4 !== 4'd8 || ir4 !== 1'b0) begin n_fail++; $display("FAIL full_8 got out=%0d ir=%b exp 8/0", out4, ir4); end
    ip4 = 2; tick();
    n_checks++; if (out4 !== 4'd8) begin n_fail++; $display("FAIL full_ninth got %0d exp 8", out4); end
    ip4 = 1; sv4 = 1; sl4 = 1; #1;
    n_checks++; if (ir4 !== 1'b0 || sr4 !== 1'b1 || mv4 !== 4'b0001)
      begin n_fail++; $display("FAIL full_popcycle got ir=%b sr=%b mv=%b exp 0/1/0001", ir4, sr4, mv4); end
    n_checks++; if (out4 !== 4'd8) begin n_fail++; $display("FAIL full_popcycle_out got %0d exp 8", out4); end
    tick();
    n_checks++; if (out4 !== 4'd7) begin n_fail++; $display("FAIL full_after_pop got %0d exp 7", out4); end
    n_checks++; if (ir4 !== 1'b1 || mv4 !== 4'b0010) begin n_fail++; $display("FAIL full_pushpop got ir=%b mv=%b exp 1/0010", ir4, mv4); end
    tick();
    n_checks++; if (out4 !== 4'd7) begin n_fail++; $display("FAIL full_pushpop_out got %0d exp 7", out4); end
    iv4 = 0;
    for (int k = 0; k < 7; k++) begin
      #1;
      n_checks++; if (mv4 !== (4'b0001 << drain[k])) begin n_fail++; $display("FAIL full_drain_%0d got %b exp port %0d", k, mv4, drain[k]); end
      tick();
    end
    n_checks++; if (out4 !== 4'd0) begin n_fail++; $display("FAIL full_empty got %0d exp 0", out4); end
    idle();
  endtask

  task automatic test_stall();
    sv4 = 1; sl4 = 1; #1;
    n_checks++; if (sr4 !== 1'b0 || mv4 !== 4'b0) begin n_fail++; $display("FAIL stall_empty got sr=%b mv=%b exp 0/0000", sr4, mv4); end
    iv4 = 1; ip4 = 1; #1;
    n_checks++; if (mv4 !== 4'b0 || sr4 !== 1'b0) begin n_fail++; $display("FAIL stall_nobypass got mv=%b sr=%b exp 0000/0", mv4, sr4); end
    tick(); iv4 = 0; #1;
    n_checks++; if (mv4 !== 4'b0010 || out4 !== 4'd1) begin n_fail++; $display("FAIL stall_next got mv=%b out=%0d exp 0010/1", mv4, out4); end
    tick();
    n_checks++; if (out4 !== 4'd0) begin n_fail++; $display("FAIL stall_pop got %0d exp 0", out4); end
    idle();
  endtask

  task automatic test_backpressure();
    iv4 = 1; ip4 = 1; tick(); iv4 = 0;
    mr4 = 4'b1101; sv4 = 1; sl4 = 1; sd4 = 32'h5A5A_0001; #1;
    n_checks++; if (sr4 !== 1'b0 || mv4 !== 4'b0010) begin n_fail++; $display("FAIL bp_hold got sr=%b mv=%b exp 0/0010", sr4, mv4); end
    tick();
    n_checks++; if (out4 !== 4'd1 || md4[63:32] !== 32'h5A5A_0001) begin n_fail++; $display("FAIL bp_held got out=%0d data=%h", out4, md4[63:32]); end
    mr4 = 4'b1111; #1;
    n_checks++; if (sr4 !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b exp 1", sr4); end
    tick();
    n_checks++; if (out4 !== 4'd0) begin n_fail++; $display("FAIL bp_pop got %0d exp 0", out4); end
    idle();
  endtask

  task automatic test_drop();
    iv3 = 1; ip3 = 3; tick(); ip3 = 0; tick(); iv3 = 0;
    n_checks++; if (da3 !== 1'b1 || out3 !== 4'd2) begin n_fail++; $display("FAIL drop_head got da=%b out=%0d exp 1/2", da3, out3); end
    sv3 = 1; sl3 = 0; sd3 = 32'hDEAD_0000; #1;
    n_checks++; if (sr3 !== 1'b1 || mv3 !== 3'b0 || ml3 !== 3'b0) begin n_fail++; $display("FAIL drop_beat0 got sr=%b mv=%b ml=%b", sr3, mv3, ml3); end
    tick();
    n_checks++; if (da3 !== 1'b1 || out3 !== 4'd2) begin n_fail++; $display("FAIL drop_mid got da=%b out=%0d exp 1/2", da3, out3); end
    sl3 = 1; #1;
    n_checks++; if (mv3 !== 3'b0) begin n_fail++; $display("FAIL drop_beat1 got %b exp 000", mv3); end
    tick();
    n_checks++; if (da3 !== 1'b0 || out3 !== 4'd1) begin n_fail++; $display("FAIL drop_done got da=%b out=%0d exp 0/1", da3, out3); end
    sl3 = 0; sd3 = 32'hBEEF_0001; #1;
    n_checks++; if (mv3 !== 3'b001 || md3[31:0] !== 32'hBEEF_0001) begin n_fail++; $display("FAIL drop_next got mv=%b data=%h", mv3, md3[31:0]); end
    tick(); sl3 = 1; tick();
    n_checks++; if (out3 !== 4'd0) begin n_fail++; $display("FAIL drop_empty got %0d exp 0", out3); end
    idle();
  endtask

  task automatic test_reset_mid();
    iv4 = 1; ip4 = 2; tick(); ip4 = 0; tick(); ip4 = 3; tick(); iv4 = 0;
    sv4 = 1; sl4 = 0; tick();
    rst = 1; iv4 = 1; ip4 = 1; sl4 = 1; tick();
    rst = 0; iv4 = 0; #1;
    n_checks++; if (out4 !== 4'd0 || ir4 !== 1'b1) begin n_fail++; $display("FAIL rstmid_state got out=%0d ir=%b exp 0/1", out4, ir4); end
    n_checks++; if (sr4 !== 1'b0 || mv4 !== 4'b0) begin n_fail++; $display("FAIL rstmid_stall got sr=%b mv=%b exp 0/0000", sr4, mv4); end
    tick();
    n_checks++; if (out4 !== 4'd0 || sr4 !== 1'b0) begin n_fail++; $display("FAIL rstmid_hold got out=%0d sr=%b exp 0/0", out4, sr4); end
    iv4 = 1; ip4 = 3; tick(); iv4 = 0;
    n_checks++; if (mv4 !== 4'b1000) begin n_fail++; $display("FAIL rstmid_newhead got %b exp 1000", mv4); end
    tick();
    n_checks++; if (out4 !== 4'd0) begin n_fail++; $display("FAIL rstmid_pop got %0d exp 0", out4); end
    idle();
  endtask

  task automatic test_wrap();
    iv4 = 1; ip4 = 0; tick();
    sv4 = 1; sl4 = 1;
    for (int k = 0; k < 20; k++) begin
      ip4 = 2'((k + 1) % 4); #1;
      n_checks++; if (mv4 !== (4'b0001 << (k % 4))) begin n_fail++; $display("FAIL wrap_head_%0d got %b exp port %0d", k, mv4, k % 4); end
      tick();
      n_checks++; if (out4 !== 4'd1) begin n_fail++; $display("FAIL wrap_out_%0d got %0d exp 1", k, out4); end
    end
    iv4 = 0; tick();
    n_checks++; if (out4 !== 4'd0) begin n_fail++; $display("FAIL wrap_drain got %0d exp 0", out4); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_order();
    test_full();
    test_stall();
    test_backpressure();
    test_drop();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
